ghost_walker: RTL and testbench

Consumes the relative-turn codes produced by the ghost random-direction source and turns them into legal ghost motion on the maze tile grid. On each movement tick it picks a candidate heading, queries the maze map for a wall at the neighbouring tile over a req/ack handshake, and falls back through a fixed candidate order until it finds a free tile. It sits between the ghost direction source and the maze ROM arbiter, and it drives the ghost tile position used by collision and rendering.

---
 rtl/ghost_pkg.sv | 37 +++
 rtl/ghost_neighbor.sv | 55 +++++
 rtl/ghost_walker.sv | 141 ++++++++++++++
 tb/tb_ghost_walker.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared ghost movement types: headings, relative turn codes and maze geometry.
// Imported by the ghost walker and by the neighbour-tile helper.
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_NEXT  = 2'd2
    } walk_state_t;

    localparam logic [3:0] TURN_LEFT     = 4'd1;
    localparam logic [3:0] TURN_STRAIGHT = 4'd2;
    localparam logic [3:0] TURN_RIGHT    = 4'd3;

    localparam int MAZE_W     = 28;
    localparam int MAZE_H     = 31;
    localparam int TUNNEL_ROW = 14;

    // Heading offset (mod 4) for a turn code; unknown codes mean straight.
    function automatic logic [1:0] turn_offset(input logic [3:0] turn);
        logic [1:0] off;
        case (turn)
            TURN_LEFT:  off = 2'd3;
            TURN_RIGHT: off = 2'd1;
            default:    off = 2'd0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/ghost_neighbor.sv
// Neighbouring tile in a given heading, with tunnel-row wrap on x.
// oor_o flags a neighbour that falls off the maze and does not wrap.
module ghost_neighbor
    import ghost_pkg::*;
#(
    parameter int MAP_W    = MAZE_W,
    parameter int MAP_H    = MAZE_H,
    parameter int TUNNEL_Y = TUNNEL_ROW
) (
    input  logic [4:0] x_i,
    input  logic [4:0] y_i,
    input  logic [1:0] dir_i,
    output logic [4:0] nx_o,
    output logic [4:0] ny_o,
    output logic       oor_o
);

    localparam logic [4:0] X_MAX = 5'(MAP_W - 1);
    localparam logic [4:0] Y_MAX = 5'(MAP_H - 1);
    localparam logic [4:0] TUN_Y = 5'(TUNNEL_Y);

    always_comb begin
        nx_o  = x_i;
        ny_o  = y_i;
        oor_o = 1'b0;
        case (dir_t'(dir_i))
            UP: begin
                if (y_i == 5'd0) oor_o = 1'b1;
                else             ny_o  = y_i - 5'd1;
            end
            DOWN: begin
                if (y_i >= Y_MAX) oor_o = 1'b1;
                else              ny_o  = y_i + 5'd1;
            end
            LEFT: begin
                if (x_i == 5'd0) begin
                    if (y_i == TUN_Y) nx_o  = X_MAX;
                    else              oor_o = 1'b1;
                end else begin
                    nx_o = x_i - 5'd1;
                end
            end
            RIGHT: begin
                if (x_i >= X_MAX) begin
                    if (y_i == TUN_Y) nx_o  = 5'd0;
                    else              oor_o = 1'b1;
                end else begin
                    nx_o = x_i + 5'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ghost_walker.sv
// Ghost mover: turns relative turn codes into legal tile moves by querying the
// maze map for each candidate heading until a free neighbour is found.
module ghost_walker
    import ghost_pkg::*;
#(
    parameter int START_X   = 13,
    parameter int START_Y   = 11,
    parameter int START_DIR = 3,
    parameter int MAP_W     = MAZE_W,
    parameter int MAP_H     = MAZE_H,
    parameter int TUNNEL_Y  = TUNNEL_ROW
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic [3:0] i_turn,
    output logic       o_map_req,
    output logic [4:0] o_map_x,
    output logic [4:0] o_map_y,
    input  logic       i_map_ack,
    input  logic       i_map_wall,
    output logic [4:0] o_x,
    output logic [4:0] o_y,
    output logic [1:0] o_dir,
    output logic       o_busy,
    output logic       o_moved,
    output logic       o_stuck
);

    localparam logic [4:0] RST_X   = 5'(START_X);
    localparam logic [4:0] RST_Y   = 5'(START_Y);
    localparam logic [1:0] RST_DIR = 2'(START_DIR);

    walk_state_t state_q;
    logic [4:0]  x_q;
    logic [4:0]  y_q;
    logic [1:0]  dir_q;
    logic [1:0]  turn_off_q;
    logic [2:0]  k_q;
    logic        moved_q;
    logic        stuck_q;

    logic [1:0]  cand_off;
    logic [1:0]  cand_dir;
    logic [4:0]  nb_x;
    logic [4:0]  nb_y;
    logic        nb_oor;
    logic        req;

    // Fallback order after the requested turn: straight, left, right, reverse.
    always_comb begin
        case (k_q)
            3'd0:    cand_off = turn_off_q;
            3'd1:    cand_off = 2'd0;
            3'd2:    cand_off = 2'd3;
            3'd3:    cand_off = 2'd1;
            default: cand_off = 2'd2;
        endcase
    end

    assign cand_dir = dir_q + cand_off;

    ghost_neighbor #(
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H),
        .TUNNEL_Y (TUNNEL_Y)
    ) u_neighbor (
        .x_i   (x_q),
        .y_i   (y_q),
        .dir_i (cand_dir),
        .nx_o  (nb_x),
        .ny_o  (nb_y),
        .oor_o (nb_oor)
    );

    // Handshake: o_map_req rises with a stable address and stays up, address
    // unchanged, until i_map_ack; i_map_wall is only looked at alongside the ack.
    // Off-map candidates never raise the request and count as a wall.
    assign req       = (state_q == S_QUERY) && !nb_oor;
    assign o_map_req = req;
    assign o_map_x   = req ? nb_x : 5'd0;
    assign o_map_y   = req ? nb_y : 5'd0;

    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_dir   = dir_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_moved = moved_q;
    assign o_stuck = stuck_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            x_q        <= RST_X;
            y_q        <= RST_Y;
            dir_q      <= RST_DIR;
            turn_off_q <= 2'd0;
            k_q        <= 3'd0;
            moved_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            stuck_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_tick) begin
                        turn_off_q <= turn_offset(i_turn);
                        k_q        <= 3'd0;
                        state_q    <= S_QUERY;
                    end
                end
                S_QUERY: begin
                    if (nb_oor) begin
                        state_q <= S_NEXT;
                    end else if (i_map_ack) begin
                        if (i_map_wall) begin
                            state_q <= S_NEXT;
                        end else begin
                            x_q     <= nb_x;
                            y_q     <= nb_y;
                            dir_q   <= cand_dir;
                            moved_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_NEXT: begin
                    if (k_q == 3'd4) begin
                        stuck_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        k_q     <= k_q + 3'd1;
                        state_q <= S_QUERY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_walker.sv
// Bench for ghost_walker: queued expectations from a tile-grid reference model,
// a map responder with random ack latency, and a negedge monitor.
module tb_ghost_walker;

    localparam int W   = 28;
    localparam int H   = 31;
    localparam int TUN = 14;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic [3:0] i_turn = 4'd0;
    logic       i_map_ack = 1'b0;
    logic       i_map_wall = 1'b0;
    logic       o_map_req;
    logic [4:0] o_map_x;
    logic [4:0] o_map_y;
    logic [4:0] o_x;
    logic [4:0] o_y;
    logic [1:0] o_dir;
    logic       o_busy;
    logic       o_moved;
    logic       o_stuck;

    ghost_walker dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_turn     (i_turn),
        .o_map_req  (o_map_req),
        .o_map_x    (o_map_x),
        .o_map_y    (o_map_y),
        .i_map_ack  (i_map_ack),
        .i_map_wall (i_map_wall),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_dir      (o_dir),
        .o_busy     (o_busy),
        .o_moved    (o_moved),
        .o_stuck    (o_stuck)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0]  exp_q[$];   // {x, y} of each expected map query
    logic [12:0] res_q[$];   // {stuck, x, y, dir} of each expected move outcome

    bit wall_map [0:H-1][0:W-1];
    int m_x = 13;
    int m_y = 11;
    int m_dir = 3;

    bit resp_en = 1'b1;
    int resp_max = 0;
    int wait_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_map(input int density);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                wall_map[y][x] = (density >= 100) ? 1'b1 :
                                 (int'($urandom_range(0, 99)) < density);
    endtask

    // Reference model: walk the candidate list on the tile grid with plain
    // integer arithmetic and queue the queries and outcome it implies.
    task automatic model_move(input logic [3:0] turn, output bit first_req);
        int dx[4] = '{0, 1, 0, -1};
        int dy[4] = '{-1, 0, 1, 0};
        int offs[5];
        int t, h, nx, ny;
        bit done;
        t = (turn == 4'd1) ? -1 : (turn == 4'd3) ? 1 : 0;
        offs = '{t, 0, -1, 1, 2};
        first_req = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!done) begin
                h  = (m_dir + offs[k] + 4) % 4;
                nx = m_x + dx[h];
                ny = m_y + dy[h];
                if (ny == TUN && nx < 0)       nx = W - 1;
                else if (ny == TUN && nx >= W) nx = 0;
                if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
                    if (k == 0) first_req = 1'b1;
                    exp_q.push_back({5'(nx), 5'(ny)});
                    if (!wall_map[ny][nx]) begin
                        res_q.push_back({1'b0, 5'(nx), 5'(ny), 2'(h)});
                        m_x = nx;
                        m_y = ny;
                        m_dir = h;
                        done = 1'b1;
                    end
                end
            end
        end
        if (!done) res_q.push_back({1'b1, 5'(m_x), 5'(m_y), 2'(m_dir)});
    endtask

    task automatic model_reset();
        exp_q.delete();
        res_q.delete();
        m_x = 13;
        m_y = 11;
        m_dir = 3;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_tick = 1'b0;
        i_map_ack = 1'b0;
        i_map_wall = 1'b0;
        wait_cnt = 0;
        @(posedge i_clk);
        #1;
        model_reset();
        i_rst_n = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, int'(o_x), 13);
        chk({tag, "_y"}, int'(o_y), 11);
        chk({tag, "_dir"}, int'(o_dir), 3);
        chk({tag, "_req"}, int'(o_map_req), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_moved"}, int'(o_moved), 0);
        chk({tag, "_stuck"}, int'(o_stuck), 0);
    endtask

    // ---------------- driver ----------------
    task automatic do_move(input logic [3:0] turn, input bit noise);
        bit first_req;
        int cyc;
        model_move(turn, first_req);
        i_tick = 1'b1;
        i_turn = turn;
        @(posedge i_clk);
        #1;
        i_tick = 1'b0;
        i_turn = 4'($urandom);
        chk("busy_after_tick", int'(o_busy), 1);
        if (first_req) chk("req_after_tick", int'(o_map_req), 1);
        cyc = 0;
        while (o_busy && cyc < 60) begin
            if (noise && $urandom_range(0, 2) == 0) begin
                i_tick = 1'b1;
                i_turn = 4'($urandom);
            end
            @(posedge i_clk);
            #1;
            i_tick = 1'b0;
            cyc++;
        end
        if (o_busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL move_timeout: busy after %0d cycles, required idle", cyc);
            apply_reset();
        end else begin
            @(negedge i_clk);
            #1;
            chk("leftover_queries", exp_q.size(), 0);
            chk("leftover_results", res_q.size(), 0);
        end
    endtask

    // ---------------- map responder ----------------
    always @(posedge i_clk) begin
        #1;
        if (resp_en && i_rst_n) begin
            if (i_map_ack) begin
                i_map_ack = 1'b0;
                i_map_wall = 1'b0;
                wait_cnt = $urandom_range(0, resp_max);
            end else if (o_map_req) begin
                if (wait_cnt == 0) begin
                    i_map_ack = 1'b1;
                    i_map_wall = wall_map[o_map_y][o_map_x];
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    bit prev_hs = 1'b0;
    bit prev_wall = 1'b0;

    always @(negedge i_clk) begin : monitor
        logic [9:0]  e;
        logic [12:0] r;
        logic [12:0] act;
        if (!i_rst_n) begin
            prev_hs = 1'b0;
            prev_wall = 1'b0;
        end else begin
            if (o_map_req && i_map_ack) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL query: got (%0d,%0d) expected no query", o_map_x, o_map_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_map_x, o_map_y} !== e) begin
                        n_err++;
                        $display("FAIL query: got (%0d,%0d) expected (%0d,%0d)",
                                 o_map_x, o_map_y, e[9:5], e[4:0]);
                    end
                end
            end
            if (!o_map_req) begin
                n_cmp++;
                if (o_map_x !== 5'd0 || o_map_y !== 5'd0) begin
                    n_err++;
                    $display("FAIL idle_addr: got (%0d,%0d) expected (0,0)", o_map_x, o_map_y);
                end
            end
            if (prev_hs && prev_wall) begin
                n_cmp++;
                if (o_map_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL wall_gap: req got %0b expected 0", o_map_req);
                end
            end
            if (o_moved || o_stuck) begin
                n_cmp++;
                act = {o_stuck, o_x, o_y, o_dir};
                if (o_moved && o_stuck) begin
                    n_err++;
                    $display("FAIL pulse_excl: moved and stuck both 1, expected one");
                end else if (res_q.size() == 0) begin
                    n_err++;
                    $display("FAIL result: got stuck=%0b (%0d,%0d) dir=%0d expected none",
                             o_stuck, o_x, o_y, o_dir);
                end else begin
                    r = res_q.pop_front();
                    if (act !== r) begin
                        n_err++;
                        $display("FAIL result: got stuck=%0b (%0d,%0d) dir=%0d expected stuck=%0b (%0d,%0d) dir=%0d",
                                 o_stuck, o_x, o_y, o_dir, r[12], r[11:7], r[6:2], r[1:0]);
                    end
                end
                if (o_moved) begin
                    n_cmp++;
                    if (!(prev_hs && !prev_wall)) begin
                        n_err++;
                        $display("FAIL moved_timing: moved got 1 expected only after free ack");
                    end
                end
            end
            prev_hs = o_map_req && i_map_ack;
            prev_wall = i_map_wall;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        fill_map(0);
        apply_reset();
        check_reset("reset");

        // Zero-latency first move, then straight down the row to column 0.
        do_move(4'd2, 1'b0);
        chk("first_x", int'(o_x), 12);
        repeat (12) do_move(4'd2, 1'b0);
        chk("edge_x", int'(o_x), 0);

        // (0,11) heading LEFT: off-map candidates skipped, falls to left=DOWN.
        do_move(4'd2, 1'b0);
        chk("oor_y", int'(o_y), 12);
        chk("oor_dir", int'(o_dir), 2);
        do_move(4'd2, 1'b0);
        do_move(4'd2, 1'b0);

        // Tunnel row: right of DOWN is LEFT, wraps from column 0 to 27.
        do_move(4'd3, 1'b0);
        chk("tunnel_x", int'(o_x), 27);
        chk("tunnel_dir", int'(o_dir), 3);

        // Every tile a wall: five queries, stuck, nothing changes.
        fill_map(100);
        do_move(4'd1, 1'b0);
        chk("stuck_x", int'(o_x), 27);
        chk("stuck_y", int'(o_y), 14);
        chk("stuck_dir", int'(o_dir), 3);

        // Randomised walk: random turn codes, ack delays and busy-time ticks.
        resp_max = 3;
        for (int seg = 0; seg < 5; seg++) begin
            fill_map(25);
            for (int n = 0; n < 30; n++) do_move(4'($urandom_range(0, 15)), 1'b1);
        end

        // Reset in the middle of a query, then a late ack in IDLE.
        fill_map(0);
        resp_max = 0;
        apply_reset();
        resp_en = 1'b0;
        i_tick = 1'b1;
        i_turn = 4'd2;
        @(posedge i_clk);
        #1;
        i_tick = 1'b0;
        chk("hold_req", int'(o_map_req), 1);
        chk("hold_map_x", int'(o_map_x), 12);
        i_tick = 1'b1;
        @(posedge i_clk);
        #1;
        i_tick = 1'b0;
        @(posedge i_clk);
        #1;
        chk("hold_req_late", int'(o_map_req), 1);
        chk("hold_x", int'(o_x), 13);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
        check_reset("midreset");
        i_map_ack = 1'b1;
        i_map_wall = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge i_clk);
            #1;
            chk("late_ack_x", int'(o_x), 13);
            chk("late_ack_moved", int'(o_moved), 0);
            chk("late_ack_busy", int'(o_busy), 0);
            chk("late_ack_req", int'(o_map_req), 0);
        end
        i_map_ack = 1'b0;
        resp_en = 1'b1;
        do_move(4'd2, 1'b0);
        chk("after_reset_x", int'(o_x), 12);

        repeat (3) @(posedge i_clk);
        chk("final_queries", exp_q.size(), 0);
        chk("final_results", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
